// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the single-port data memory.
// Each granted request produces one memory access (or none on error) and one response pulse.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [2:0]  r0_func3,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [2:0]  r1_func3,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_func3,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state, next_state;
  logic        last;
  logic        id_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  func3_q;
  logic        err_q;
  logic [31:0] resp_data;

  logic        win1;
  logic        grant;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_func3;
  logic        sel_err;
  logic        resp_on;

  // Last byte touched is computed in 33 bits so addresses near the top never wrap into range.
  function automatic logic access_error(input logic we, input logic [2:0] f3,
                                        input logic [31:0] addr);
    logic        bad_f3;
    logic        misaligned;
    logic [1:0]  size_m1;
    logic [32:0] last_byte;
    bad_f3     = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misaligned = ((f3[1:0] == 2'd2) && (addr[1:0] != 2'd0)) ||
                 ((f3[1:0] == 2'd1) && addr[0]);
    case (f3[1:0])
      2'd0:    size_m1 = 2'd0;
      2'd1:    size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
    last_byte = {1'b0, addr} + {31'b0, size_m1};
    return bad_f3 || misaligned || (last_byte >= MEM_LIMIT);
  endfunction

  always_comb begin
    win1      = r1_req && (!r0_req || !last);
    grant     = (state == IDLE) && !rst && (r0_req || r1_req);
    sel_we    = win1 ? r1_we    : r0_we;
    sel_addr  = win1 ? r1_addr  : r0_addr;
    sel_wdata = win1 ? r1_wdata : r0_wdata;
    sel_func3 = win1 ? r1_func3 : r0_func3;
    sel_err   = access_error(sel_we, sel_func3, sel_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      id_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      func3_q   <= '0;
      err_q     <= 1'b0;
      resp_data <= '0;
    end else begin
      state <= next_state;
      if (grant) begin
        last      <= win1;
        id_q      <= win1;
        we_q      <= sel_we;
        addr_q    <= sel_addr;
        wdata_q   <= sel_wdata;
        func3_q   <= sel_func3;
        err_q     <= sel_err;
        resp_data <= '0;
      end
      if (state == ACCESS) begin
        resp_data <= we_q ? '0 : mem_data_out;
      end
    end
  end

  always_comb begin
    next_state     = state;
    r0_gnt         = 1'b0;
    r1_gnt         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_func3      = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    resp_on        = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          r0_gnt     = !win1;
          r1_gnt     = win1;
          next_state = sel_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!rst) begin
          mem_addr       = addr_q;
          mem_write_data = wdata_q;
          mem_func3      = func3_q;
          mem_write      = we_q;
          mem_read       = !we_q;
        end
        next_state = RESP;
      end
      RESP: begin
        resp_on    = !rst;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign r0_rvalid = resp_on && !id_q;
  assign r1_rvalid = resp_on && id_q;
  assign r0_err    = r0_rvalid && err_q;
  assign r1_err    = r1_rvalid && err_q;
  assign r0_rdata  = r0_rvalid ? resp_data : '0;
  assign r1_rdata  = r1_rvalid ? resp_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a little-endian byte memory model behind it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [2:0]  r0_func3, r1_func3;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_data_out;
  logic [2:0]  mem_func3;
  logic        mem_write, mem_read;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_func3(r0_func3), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_func3(r1_func3), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .r1_err(r1_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_func3(mem_func3),
    .mem_write(mem_write), .mem_read(mem_read), .mem_data_out(mem_data_out)
  );

  // Memory model: combinational, width/sign handled from func3, write on rising edge.
  logic [7:0] mem [1024];
  logic [9:0] ma;
  logic [7:0] b0;
  logic [15:0] h0;

  always_comb begin
    ma = mem_addr[9:0];
    b0 = mem[ma];
    h0 = {mem[ma + 10'd1], mem[ma]};
    mem_data_out = '0;
    if (mem_read) begin
      case (mem_func3)
        3'd0: mem_data_out = {{24{b0[7]}}, b0};
        3'd1: mem_data_out = {{16{h0[15]}}, h0};
        3'd2: mem_data_out = {mem[ma + 10'd3], mem[ma + 10'd2], h0};
        3'd4: mem_data_out = {24'b0, b0};
        3'd5: mem_data_out = {16'b0, h0};
        default: mem_data_out = '0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_write) begin
      mem[ma] <= mem_write_data[7:0];
      if (mem_func3 != 3'd0) mem[ma + 10'd1] <= mem_write_data[15:8];
      if (mem_func3 == 3'd2) begin
        mem[ma + 10'd2] <= mem_write_data[23:16];
        mem[ma + 10'd3] <= mem_write_data[31:24];
      end
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic port, input logic req, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    if (!port) begin
      r0_req = req; r0_we = we; r0_func3 = f3; r0_addr = addr; r0_wdata = wd;
    end else begin
      r1_req = req; r1_we = we; r1_func3 = f3; r1_addr = addr; r1_wdata = wd;
    end
  endtask

  function automatic logic gnt_of(input logic port);
    return port ? r1_gnt : r0_gnt;
  endfunction
  function automatic logic rv_of(input logic port);
    return port ? r1_rvalid : r0_rvalid;
  endfunction
  function automatic logic err_of(input logic port);
    return port ? r1_err : r0_err;
  endfunction
  function automatic logic [31:0] rd_of(input logic port);
    return port ? r1_rdata : r0_rdata;
  endfunction

  // Request must already be driven at a negedge; follows it through grant and response.
  task automatic run_txn(input string tag, input vec_t v);
    int cyc = 0;
    #1;
    while (!gnt_of(v.port) && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    check({tag, " gnt"}, 32'(gnt_of(v.port)), 32'd1);
    check({tag, " other gnt"}, 32'(gnt_of(!v.port)), 32'd0);
    @(posedge clk); #1;
    set_req(v.port, 1'b0, 1'b0, 3'd0, '0, '0);
    @(negedge clk);
    if (v.err) begin
      check({tag, " err rvalid"}, 32'(rv_of(v.port)), 32'd1);
      check({tag, " err flag"}, 32'(err_of(v.port)), 32'd1);
      check({tag, " err rdata"}, rd_of(v.port), 32'd0);
      check({tag, " err strobes"}, {30'b0, mem_read, mem_write}, 32'd0);
    end else begin
      check({tag, " mem_write"}, 32'(mem_write), 32'(v.we));
      check({tag, " mem_read"}, 32'(mem_read), 32'(!v.we));
      check({tag, " mem_addr"}, mem_addr, v.addr);
      check({tag, " early rvalid"}, 32'(rv_of(v.port)), 32'd0);
      @(negedge clk);
      check({tag, " rvalid"}, 32'(rv_of(v.port)), 32'd1);
      check({tag, " err"}, 32'(err_of(v.port)), 32'd0);
      check({tag, " rdata"}, rd_of(v.port), v.rdata);
      check({tag, " other rvalid"}, 32'(rv_of(!v.port)), 32'd0);
      check({tag, " resp strobes"}, {30'b0, mem_read, mem_write}, 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    //             port  we    f3    addr            wdata          err   rdata
    vecs[0]  = '{1'b0, 1'b1, 3'd2, 32'h10,        32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 3'd2, 32'h10,        32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 3'd0, 32'h20,        32'h00000080, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 3'd0, 32'h20,        32'h0,        1'b0, 32'hFFFFFF80};
    vecs[4]  = '{1'b0, 1'b0, 3'd4, 32'h20,        32'h0,        1'b0, 32'h00000080};
    vecs[5]  = '{1'b0, 1'b1, 3'd1, 32'h30,        32'h00008001, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 3'd1, 32'h30,        32'h0,        1'b0, 32'hFFFF8001};
    vecs[7]  = '{1'b0, 1'b0, 3'd5, 32'h30,        32'h0,        1'b0, 32'h00008001};
    vecs[8]  = '{1'b0, 1'b0, 3'd2, 32'h13,        32'h0,        1'b1, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 3'd1, 32'h11,        32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 3'd2, 32'd1022,      32'h12345678, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 3'd3, 32'h0,         32'h0,        1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 3'd4, 32'h0,         32'h0,        1'b1, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 3'd2, 32'hFFFFFFFC,  32'h0,        1'b1, 32'h0};
    vecs[14] = '{1'b1, 1'b1, 3'd2, 32'd1020,      32'hCAFEF00D, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 3'd2, 32'd1020,      32'h0,        1'b0, 32'hCAFEF00D};
    vecs[16] = '{1'b1, 1'b0, 3'd4, 32'd1023,      32'h0,        1'b0, 32'h000000CA};
    vecs[17] = '{1'b1, 1'b0, 3'd2, 32'd1021,      32'h0,        1'b1, 32'h0};
    vecs[18] = '{1'b0, 1'b1, 3'd2, 32'h40,        32'h11223344, 1'b0, 32'h0};

    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, 3'd0, '0, '0);
    repeat (3) @(negedge clk);
    check("reset gnt0", 32'(r0_gnt), 32'd0);
    rst = 1'b0;
    #1;
    check("reset outputs", {26'b0, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_read, mem_write}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset rdata", r0_rdata | r1_rdata, 32'd0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      v = vecs[i];
      set_req(v.port, 1'b1, v.we, v.f3, v.addr, v.wdata);
      run_txn($sformatf("vec%0d", i), v);
    end

    // Contention from reset: both hold loads continuously, r0 must win first.
    @(negedge clk);
    rst = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 3'd2, 32'h10, '0);
    set_req(1'b1, 1'b1, 1'b0, 3'd2, 32'd1020, '0);
    @(negedge clk); #1;
    check("gnt during reset", {30'b0, r0_gnt, r1_gnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      check($sformatf("cont c%0d gnt0", c), 32'(r0_gnt), 32'(c % 6 == 0));
      check($sformatf("cont c%0d gnt1", c), 32'(r1_gnt), 32'(c % 6 == 3));
      check($sformatf("cont c%0d rv0", c), 32'(r0_rvalid), 32'(c % 6 == 2));
      check($sformatf("cont c%0d rv1", c), 32'(r1_rvalid), 32'(c % 6 == 5));
      if (c % 6 == 2) check($sformatf("cont c%0d rdata0", c), r0_rdata, 32'hDEADBEEF);
      if (c % 6 == 5) check($sformatf("cont c%0d rdata1", c), r1_rdata, 32'hCAFEF00D);
      if (c == 11) begin
        set_req(1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, 3'd0, '0, '0);
      end
      @(negedge clk);
    end

    // Reset lands on the ACCESS cycle of a store: memory must keep the old word.
    set_req(1'b0, 1'b1, 1'b1, 3'd2, 32'h40, 32'h55667788);
    begin
      int cyc = 0;
      #1;
      while (!r0_gnt && cyc < 20) begin
        @(negedge clk); #1; cyc++;
      end
      check("rst-store gnt", 32'(r0_gnt), 32'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
    @(negedge clk);
    check("rst-store mem_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    check("rst-store no rvalid", {30'b0, r0_rvalid, r1_rvalid}, 32'd0);
    set_req(1'b0, 1'b1, 1'b0, 3'd2, 32'h40, '0);
    set_req(1'b1, 1'b1, 1'b0, 3'd2, 32'h10, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset r1 not first", 32'(r1_gnt), 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 3'd0, '0, '0);
    v = '{1'b0, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 32'h11223344};
    run_txn("post-reset LW", v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
